// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared pipeline-buffer package: stage-register typedefs plus the fetch
//   stage's buffer entry, FSM state type and default geometry.
//
//   Contents:
//     FETCH_PC_W / FETCH_INS_W / FETCH_FIFO_DEPTH  default fetch geometry
//     FETCH_RESET_PC                               fetch address after reset
//     fetch_state_t                                RUN / DRAIN fetch FSM states
//     fetch_entry_t                                {pc, instr} buffer entry
//     if_id_reg_t                                  IF/ID stage register image
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int FETCH_PC_W       = 9;
    localparam int FETCH_INS_W      = 32;
    localparam int FETCH_FIFO_DEPTH = 4;

    localparam logic [FETCH_PC_W-1:0] FETCH_RESET_PC = '0;

    // RUN: responses are kept. DRAIN: responses to requests issued before the
    // last redirect are still in flight and must be thrown away.
    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_DRAIN = 1'b1
    } fetch_state_t;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [FETCH_PC_W-1:0]  pc;
        logic [FETCH_INS_W-1:0] instr;
    } fetch_entry_t;

    // Image of the IF/ID pipeline register fed by the fetch stage.
    typedef struct packed {
        logic                   valid;
        logic [FETCH_PC_W-1:0]  pc;
        logic [FETCH_INS_W-1:0] instr;
    } if_id_reg_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO with a flush input, parameterised by depth and element
//   type. Storage is registered: an element pushed in cycle t is visible at the
//   head no earlier than cycle t+1 (no write-through bypass).
//
//   Ports:
//     clk        clock
//     reset      synchronous active-high reset, empties the FIFO
//     flush      synchronous flush, empties the FIFO
//     push       write push_data (ignored when full unless popping too)
//     push_data  element to write
//     pop        remove the head element (ignored when empty)
//     head       current head element (undefined contents when empty)
//     count      number of stored elements, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           empty;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so push-while-full is accepted.
    assign do_push = push && (!full || do_pop);

    assign head = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Element storage needs no reset: nothing is read before it is written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage in front of the IF/ID register. Issues in-order
//   word fetches to instruction memory, buffers the returned instructions with
//   their PCs, and hands them to decode under valid/ready. Branch redirects
//   flush the buffer and discard responses still in flight for the old path.
//
//   Ports:
//     clk          clock
//     reset        synchronous active-high reset
//     redirect     branch taken / flush from EX
//     redirect_pc  redirect target, bits [1:0] ignored
//     if_ready     decode accepts the presented instruction
//     if_valid     if_pc / if_instr are valid
//     if_pc        PC of presented instruction (0 when not valid)
//     if_instr     presented instruction (0 when not valid)
//     imem_req     fetch request
//     imem_addr    word-aligned fetch address
//     imem_ready   memory accepts the request this cycle
//     imem_rvalid  response valid, responses in request order
//     imem_rdata   response instruction
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W       = FETCH_PC_W,
    parameter int              INS_W      = FETCH_INS_W,
    parameter int              FIFO_DEPTH = FETCH_FIFO_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC   = FETCH_RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             if_ready,
    output logic             if_valid,
    output logic [PC_W-1:0]  if_pc,
    output logic [INS_W-1:0] if_instr,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  fetch_pc_next;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] drop_cnt_next;

    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] tag_count;
    fetch_entry_t     buf_head;
    fetch_entry_t     buf_push_data;
    logic [PC_W-1:0]  tag_head;

    logic             credit_ok;
    logic             accept;
    logic             rsp;
    logic             keep_rsp;
    logic             pop_out;

    // Credit: an issued request always has a reserved buffer slot, so the
    // memory never needs back-pressure on responses.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, buf_count}) < (CNT_W+1)'(FIFO_DEPTH);

    assign imem_req  = !reset && !redirect && credit_ok;
    assign imem_addr = reset ? RESET_PC : fetch_pc;
    assign accept    = imem_req && imem_ready;

    // Responses only count while something is actually outstanding.
    assign rsp      = imem_rvalid && !reset && (outstanding != '0);
    assign keep_rsp = rsp && !redirect && (state == FETCH_RUN) && (tag_count != '0);

    assign if_valid = !reset && (buf_count != '0) && !redirect;
    assign if_pc    = if_valid ? buf_head.pc    : '0;
    assign if_instr = if_valid ? buf_head.instr : '0;
    assign pop_out  = if_valid && if_ready;

    assign buf_push_data.pc    = tag_head;
    assign buf_push_data.instr = imem_rdata;

    // Output buffer: instructions ready for decode.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (keep_rsp),
        .push_data (buf_push_data),
        .pop       (pop_out),
        .head      (buf_head),
        .count     (buf_count)
    );

    // Tag queue: PCs of kept requests still in flight, in issue order. It is
    // flushed on redirect, so dropped responses never consume a tag.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (logic [PC_W-1:0])
    ) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (keep_rsp),
        .head      (tag_head),
        .count     (tag_count)
    );

    // Next-state logic. Redirect wins over everything: it retargets the PC and
    // turns every request still in flight (after this cycle's response, which
    // is itself discarded) into a response to be dropped.
    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        outstanding_next = outstanding;
        drop_cnt_next    = drop_cnt;

        if (redirect) begin
            fetch_pc_next    = redirect_pc & ~PC_W'(3);
            outstanding_next = outstanding - CNT_W'(rsp);
            drop_cnt_next    = outstanding - CNT_W'(rsp);
            state_next       = (drop_cnt_next != '0) ? FETCH_DRAIN : FETCH_RUN;
        end else begin
            if (accept) begin
                fetch_pc_next = fetch_pc + PC_W'(4);
            end
            outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(rsp);
            if ((state == FETCH_DRAIN) && rsp) begin
                drop_cnt_next = drop_cnt - CNT_W'(1);
                if (drop_cnt_next == '0) begin
                    state_next = FETCH_RUN;
                end
            end
        end
    end

    // State register for the FSM, PC and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH_RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

endmodule
